// File: rtl/if_id_queue.sv
// IF/ID queue: DEPTH-entry FIFO of {instruction, address} between fetch and decode; empty shows NOP at RESET_ADDR.
// Latency: a pushed entry reaches the outputs one cycle after its push edge; there is no same-cycle bypass.
// Backpressure: in_ready_o depends only on registered occupancy, so a pop from full reopens input one cycle later.
module if_id_queue #(
    parameter int unsigned         DATA_W     = 32,
    parameter int unsigned         ADDR_W     = 32,
    parameter int unsigned         DEPTH      = 2,
    parameter logic [ADDR_W-1:0]   RESET_ADDR = '0,
    parameter logic [DATA_W-1:0]   NOP_INS    = DATA_W'(32'h0000_0013)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_W-1:0]        ins_i,
    input  logic [ADDR_W-1:0]        ins_addr_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        ins_o,
    output logic [ADDR_W-1:0]        ins_addr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned        PTR_W    = $clog2(DEPTH);
    localparam int unsigned        CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] ins_mem  [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign in_ready_o  = (count != FULL_CNT);
    assign out_valid_o = (count != '0);

    // Flush wins over both handshakes: the incoming beat is dropped and the head is not consumed.
    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr]  <= ins_i;
            addr_mem[wr_ptr] <= ins_addr_i;
        end
    end

    assign ins_o      = out_valid_o ? ins_mem[rd_ptr]  : NOP_INS;
    assign ins_addr_o = out_valid_o ? addr_mem[rd_ptr] : RESET_ADDR;
    assign count_o    = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table on DEPTH=2, hand-written async-reset sequence,
// and a queue-model scoreboard on DEPTH=4 and DEPTH=8 under random handshakes with periodic flush.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] IA = 32'h0050_0093, AA = 32'h0;
    localparam logic [31:0] IB = 32'h0010_0113, AB = 32'h4;
    localparam logic [31:0] IC = 32'h0020_0193, AC = 32'h8;
    localparam logic [31:0] ID = 32'h0030_0213, AD = 32'hC;
    localparam logic [31:0] IE = 32'h0040_0293, AE = 32'h10;
    localparam logic [31:0] IF = 32'h0050_0313, AF = 32'h14;
    localparam logic [31:0] IG = 32'h0060_0393, AG = 32'h18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] ins_in;
    logic [31:0] addr_in;

    logic        rdy2, vld2, rdy4, vld4, rdy8, vld8;
    logic [31:0] ins2, addr2, ins4, addr4, ins8, addr8;
    logic [1:0]  cnt2;
    logic [2:0]  cnt4;
    logic [3:0]  cnt8;

    if_id_queue #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy2),
        .ins_i(ins_in), .ins_addr_i(addr_in), .out_valid_o(vld2), .out_ready_i(out_ready),
        .ins_o(ins2), .ins_addr_o(addr2), .count_o(cnt2));

    if_id_queue #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .ins_i(ins_in), .ins_addr_i(addr_in), .out_valid_o(vld4), .out_ready_i(out_ready),
        .ins_o(ins4), .ins_addr_o(addr4), .count_o(cnt4));

    if_id_queue #(.DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy8),
        .ins_i(ins_in), .ins_addr_i(addr_in), .out_valid_o(vld8), .out_ready_i(out_ready),
        .ins_o(ins8), .ins_addr_o(addr8), .count_o(cnt8));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One row: inputs for a cycle and the outputs expected during that cycle (before its edge).
    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] ins;
        logic [31:0] adr;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [31:0] e_adr;
        int          e_cnt;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] ins,
                                input logic [31:0] adr, input logic ordy, input logic e_rdy,
                                input logic e_vld, input logic [31:0] e_ins,
                                input logic [31:0] e_adr, input int e_cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ins = ins; v.adr = adr; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_ins = e_ins; v.e_adr = e_adr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic model_chk(input string tag, input int depth, input int size,
                             input logic [63:0] head, input logic rdy, input logic vld,
                             input logic [31:0] ins, input logic [31:0] adr, input int cnt);
        chk({tag, " count"}, 64'(cnt), 64'(size));
        chk({tag, " in_ready"}, 64'(rdy), 64'(size != depth));
        chk({tag, " out_valid"}, 64'(vld), 64'(size != 0));
        chk({tag, " ins"}, 64'(ins), (size != 0) ? 64'(head[63:32]) : 64'(NOP));
        chk({tag, " addr"}, 64'(adr), (size != 0) ? 64'(head[31:0]) : 64'h0);
    endtask

    logic [63:0] q4 [$];
    logic [63:0] q8 [$];

    initial begin
        //                 fl iv ins  adr ordy  rdy vld e_ins e_adr cnt
        tbl[0]  = mk(0, 1, IA, AA, 1,   1, 0, NOP, 0,  0);
        tbl[1]  = mk(0, 1, IB, AB, 1,   1, 1, IA,  AA, 1);
        tbl[2]  = mk(0, 0, 0,  0,  1,   1, 1, IB,  AB, 1);
        tbl[3]  = mk(0, 0, 0,  0,  1,   1, 0, NOP, 0,  0);
        tbl[4]  = mk(0, 1, IA, AA, 0,   1, 0, NOP, 0,  0);
        tbl[5]  = mk(0, 1, IB, AB, 0,   1, 1, IA,  AA, 1);
        tbl[6]  = mk(0, 1, IC, AC, 0,   0, 1, IA,  AA, 2);
        tbl[7]  = mk(0, 1, ID, AD, 0,   0, 1, IA,  AA, 2);
        tbl[8]  = mk(0, 1, IC, AC, 1,   0, 1, IA,  AA, 2);
        tbl[9]  = mk(0, 1, IC, AC, 1,   1, 1, IB,  AB, 1);
        tbl[10] = mk(0, 1, ID, AD, 1,   1, 1, IC,  AC, 1);
        tbl[11] = mk(0, 1, IE, AE, 1,   1, 1, ID,  AD, 1);
        tbl[12] = mk(0, 1, IF, AF, 1,   1, 1, IE,  AE, 1);
        tbl[13] = mk(0, 1, IG, AG, 1,   1, 1, IF,  AF, 1);
        tbl[14] = mk(0, 0, 0,  0,  1,   1, 1, IG,  AG, 1);
        tbl[15] = mk(0, 0, 0,  0,  1,   1, 0, NOP, 0,  0);
        tbl[16] = mk(0, 1, IA, AA, 0,   1, 0, NOP, 0,  0);
        tbl[17] = mk(0, 1, IB, AB, 0,   1, 1, IA,  AA, 1);
        tbl[18] = mk(1, 1, IC, AC, 1,   0, 1, IA,  AA, 2);
        tbl[19] = mk(0, 0, 0,  0,  0,   1, 0, NOP, 0,  0);
        tbl[20] = mk(0, 1, ID, AD, 0,   1, 0, NOP, 0,  0);
        tbl[21] = mk(0, 0, 0,  0,  0,   1, 1, ID,  AD, 1);
        tbl[22] = mk(0, 0, 0,  0,  1,   1, 1, ID,  AD, 1);
        tbl[23] = mk(0, 0, 0,  0,  0,   1, 0, NOP, 0,  0);
        tbl[24] = mk(1, 0, 0,  0,  1,   1, 0, NOP, 0,  0);
        tbl[25] = mk(0, 1, IA, AA, 0,   1, 0, NOP, 0,  0);
        tbl[26] = mk(0, 0, 0,  0,  1,   1, 1, IA,  AA, 1);
        tbl[27] = mk(0, 0, 0,  0,  0,   1, 0, NOP, 0,  0);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ins_in = '0; addr_in = '0;
        #12;
        chk("reset in_ready", 64'(rdy2), 64'd1);
        chk("reset out_valid", 64'(vld2), 64'd0);
        chk("reset ins", 64'(ins2), 64'(NOP));
        chk("reset addr", 64'(addr2), 64'h0);
        chk("reset count", 64'(cnt2), 64'd0);
        chk("reset count d8", 64'(cnt8), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            flush = tbl[i].fl; in_valid = tbl[i].iv; ins_in = tbl[i].ins;
            addr_in = tbl[i].adr; out_ready = tbl[i].ordy;
            #4;
            chk($sformatf("row%0d in_ready", i), 64'(rdy2), 64'(tbl[i].e_rdy));
            chk($sformatf("row%0d out_valid", i), 64'(vld2), 64'(tbl[i].e_vld));
            chk($sformatf("row%0d ins", i), 64'(ins2), 64'(tbl[i].e_ins));
            chk($sformatf("row%0d addr", i), 64'(addr2), 64'(tbl[i].e_adr));
            chk($sformatf("row%0d count", i), 64'(cnt2), 64'(tbl[i].e_cnt));
            @(posedge clk); #1;
        end

        // Async reset mid-stream on a full queue, held for about a third of a period.
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; ins_in = IA; addr_in = AA;
        @(posedge clk); #1 ins_in = IB; addr_in = AB;
        @(posedge clk); #1 in_valid = 1'b0;
        chk("pre-reset count", 64'(cnt2), 64'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(vld2), 64'd0);
        chk("async reset ins", 64'(ins2), 64'(NOP));
        chk("async reset addr", 64'(addr2), 64'h0);
        chk("async reset count", 64'(cnt2), 64'd0);
        chk("async reset in_ready", 64'(rdy2), 64'd1);
        #2 rst_n = 1'b1;
        @(posedge clk); #1 in_valid = 1'b1; ins_in = IC; addr_in = AC;
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        #3;
        chk("resume ins", 64'(ins2), 64'(IC));
        chk("resume addr", 64'(addr2), 64'(AC));
        chk("resume count", 64'(cnt2), 64'd1);
        @(posedge clk); #1;
        chk("resume drained", 64'(vld2), 64'd0);

        // Resynchronise all instances before the randomised phase.
        out_ready = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            flush     = ((cyc % 37) == 36) || ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ins_in    = $urandom;
            addr_in   = $urandom;
            #4;
            model_chk($sformatf("d4 cyc%0d", cyc), 4, q4.size(), (q4.size() != 0) ? q4[0] : 64'h0,
                      rdy4, vld4, ins4, addr4, int'(cnt4));
            model_chk($sformatf("d8 cyc%0d", cyc), 8, q8.size(), (q8.size() != 0) ? q8[0] : 64'h0,
                      rdy8, vld8, ins8, addr8, int'(cnt8));
            if (flush) begin
                q4.delete();
                q8.delete();
            end else begin
                automatic bit push4 = in_valid && (q4.size() != 4);
                automatic bit push8 = in_valid && (q8.size() != 8);
                if (out_ready && (q4.size() != 0)) void'(q4.pop_front());
                if (out_ready && (q8.size() != 0)) void'(q8.pop_front());
                if (push4) q4.push_back({ins_in, addr_in});
                if (push8) q8.push_back({ins_in, addr_in});
            end
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
